// File: rtl/fpga_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_cfg_pkg
//  Description : Shared types and header-field constants for the fabric
//                configuration loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpga_cfg_pkg;

    // Programming word / stream word width
    localparam int CFG_W     = 32;

    // Header word field positions
    localparam int CHAIN_MSB = 31;
    localparam int CHAIN_LSB = 24;
    localparam int CNT_MSB   = 15;

    localparam int CHAIN_FW  = CHAIN_MSB - CHAIN_LSB + 1;
    localparam int CNT_W     = CNT_MSB + 1;

    // Loader sequencing states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
        S_SKIP  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } cfg_state_e;

    // Width of a chain index; a single chain still needs one bit
    function automatic int chain_idx_w(input int chains);
        return (chains > 1) ? $clog2(chains) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_cfg_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_cfg_loader_if
//  Description : Valid/ready configuration stream carrying framed bitstream
//                words (header, payload, checksum) into the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpga_cfg_loader_if import fpga_cfg_pkg::*; ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_last;

    // Stream source side
    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    // Loader side
    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/fpga_cfg_loader_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_onehot_dec
//  Description : Registered chain-index to one-hot shift-strobe decoder with
//                enable; output is all-zero whenever the enable is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_onehot_dec #(
    parameter int CHAINS = 5,
    parameter int IDX_W  = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_en,
    input  wire logic [IDX_W-1:0]  i_idx,
    output logic      [CHAINS-1:0] o_onehot
);

    logic [CHAINS-1:0] w_dec;
    logic [CHAINS-1:0] r_onehot;

    // Compare against each chain number; indices beyond CHAINS-1 decode to zero
    for (genvar gi = 0; gi < CHAINS; gi++) begin : g_bit
        assign w_dec[gi] = i_en && (i_idx == IDX_W'(gi));
    end

    // Register the strobe so it lines up with the registered programming word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_onehot <= '0;
        end else begin
            r_onehot <= w_dec;
        end
    end

    assign o_onehot = r_onehot;

endmodule
`default_nettype wire

// File: rtl/fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_cfg_loader
//  Description : Streaming configuration controller. Parses framed bitstream
//                words, steers payload into the addressed programming chain,
//                verifies each frame with an XOR checksum and gates the fabric
//                data enable while loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int H      = 2,
    parameter int CHAINS = 2 * H + 1
) (
    input  wire logic              clk,
    input  wire logic              res,
    input  wire logic              start,
    fpga_cfg_loader_if.slave       cfg,
    output logic      [CFG_W-1:0]  prog_o,
    output logic      [CHAINS-1:0] prog_shft,
    output logic                   data_en_o,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int                CIDX_W   = chain_idx_w(CHAINS);
    localparam logic [CHAIN_FW:0] C_CHAINS = CHAINS[CHAIN_FW:0];

    cfg_state_e          r_state;
    cfg_state_e          w_state_nxt;
    logic [CIDX_W-1:0]   r_chain;
    logic [CNT_W-1:0]    r_cnt;
    logic [CFG_W-1:0]    r_xor;
    logic [CFG_W-1:0]    r_prog;
    logic                r_cfg_ready;
    logic                r_done;
    logic                r_err;

    logic                w_acc;
    logic                w_start_ok;
    logic                w_cnt_last;
    logic                w_load_en;
    logic [CHAIN_FW-1:0] w_hdr_chain;
    logic [CNT_W-1:0]    w_hdr_cnt;
    logic                w_hdr_bad;
    logic                w_busy;

    assign w_acc       = cfg.cfg_valid && r_cfg_ready;
    // start is only honoured when no load is in flight
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cnt_last  = (r_cnt == CNT_W'(1));
    assign w_hdr_chain = cfg.cfg_data[CHAIN_MSB:CHAIN_LSB];
    assign w_hdr_cnt   = cfg.cfg_data[CNT_MSB:0];
    assign w_hdr_bad   = ({1'b0, w_hdr_chain} >= C_CHAINS);
    assign w_load_en   = w_acc && (r_state == S_LOAD);
    assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; nothing moves on a stalled stream
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_acc) begin
                    // A zero-length frame goes straight to its checksum, even
                    // when the chain is out of range, so no word is swallowed.
                    if (w_hdr_cnt == '0) begin
                        w_state_nxt = S_CHECK;
                    end else if (w_hdr_bad) begin
                        w_state_nxt = S_SKIP;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD, S_SKIP: begin
                if (w_acc && w_cnt_last) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_acc) begin
                    w_state_nxt = cfg.cfg_last ? S_DONE : S_HDR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ready is a registered decode of the state the loader is entering
    always_ff @(posedge clk) begin
        if (res) begin
            r_cfg_ready <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt == S_HDR)  || (w_state_nxt == S_LOAD) ||
                           (w_state_nxt == S_SKIP) || (w_state_nxt == S_CHECK);
        end
    end

    // Frame datapath: chain/count latch, running XOR, programming word, status
    always_ff @(posedge clk) begin
        if (res) begin
            r_chain <= '0;
            r_cnt   <= '0;
            r_xor   <= '0;
            r_prog  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_acc && (r_state == S_CHECK) && cfg.cfg_last;
            if (w_start_ok) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_HDR: begin
                    if (w_acc) begin
                        r_chain <= w_hdr_chain[CIDX_W-1:0];
                        r_cnt   <= w_hdr_cnt;
                        r_xor   <= '0;
                        if (w_hdr_bad) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_acc) begin
                        r_prog <= cfg.cfg_data;
                        r_xor  <= r_xor ^ cfg.cfg_data;
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_SKIP: begin
                    // Discarded payload still contributes to the checksum
                    if (w_acc) begin
                        r_xor <= r_xor ^ cfg.cfg_data;
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (w_acc && (cfg.cfg_data != r_xor)) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    cfg_onehot_dec #(
        .CHAINS (CHAINS),
        .IDX_W  (CIDX_W)
    ) u_dec (
        .clk      (clk),
        .rst      (res),
        .i_en     (w_load_en),
        .i_idx    (r_chain),
        .o_onehot (prog_shft)
    );

    assign cfg.cfg_ready = r_cfg_ready;
    assign prog_o        = r_prog;
    assign busy          = w_busy;
    assign data_en_o     = !w_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpga_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpga_cfg_loader
//  Description : Self-checking bench for fpga_cfg_loader. Frames are built
//                from a list of payload words; the expected shift strobes and
//                done/err outcome are pushed to scoreboard queues, and a
//                monitor pops them as the loader presents strobes and done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_cfg_loader;

    localparam int H      = 2;
    localparam int CHAINS = 2 * H + 1;

    logic              clk = 1'b0;
    logic              res;
    logic              start;
    logic [31:0]       prog_o;
    logic [CHAINS-1:0] prog_shft;
    logic              data_en_o;
    logic              busy;
    logic              done;
    logic              err;

    fpga_cfg_loader_if cfg_if ();

    fpga_cfg_loader #(
        .H      (H),
        .CHAINS (CHAINS)
    ) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .cfg       (cfg_if.slave),
        .prog_o    (prog_o),
        .prog_shft (prog_shft),
        .data_en_o (data_en_o),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          stalls   = 0;
    bit          mon_en   = 0;
    bit          m_err;

    logic [39:0] exp_shft[$];   // {chain, word}
    logic        exp_done[$];   // err expected at done
    logic [31:0] pay[$];
    logic [31:0] stim_d[$];
    logic        stim_l[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic [39:0] e;
        logic        de;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prog_shft != '0) begin
                    if (exp_shft.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_shft: got %0h expected none", prog_shft);
                    end else begin
                        e = exp_shft.pop_front();
                        check("shft_strobe", 64'(prog_shft), 64'(1) << e[39:32]);
                        check("prog_word", 64'(prog_o), 64'(e[31:0]));
                        check("data_en_while_loading", 64'(data_en_o), 64'(0));
                    end
                end
                if (done == 1'b1) begin
                    if (exp_done.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_done: got 1 expected 0");
                    end else begin
                        de = exp_done.pop_front();
                        check("err_at_done", 64'(err), 64'(de));
                        check("busy_at_done", 64'(busy), 64'(0));
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic begin_stream();
        m_err = 0;
        stim_d.delete();
        stim_l.delete();
    endtask

    // Reference model: one frame from the words in pay[]
    task automatic add_frame(input int chain, input logic [31:0] delta, input bit last);
        logic [31:0] x;
        x = '0;
        stim_d.push_back({8'(chain), 8'($urandom), 16'(pay.size())});
        stim_l.push_back(1'($urandom_range(0, 1)));
        foreach (pay[i]) begin
            x ^= pay[i];
            stim_d.push_back(pay[i]);
            stim_l.push_back(1'($urandom_range(0, 1)));
            if (chain < CHAINS) exp_shft.push_back({8'(chain), pay[i]});
        end
        stim_d.push_back(x ^ delta);
        stim_l.push_back(last);
        if (chain >= CHAINS || delta != 0) m_err = 1;
        if (last) exp_done.push_back(m_err);
    endtask

    // gaps: 0 none, 1 random, 2 one idle cycle before every word
    task automatic send_word(input logic [31:0] d, input logic l, input int gaps, input logic st);
        int w;
        if (gaps == 2 || (gaps == 1 && $urandom_range(0, 2) == 0)) begin
            cfg_if.cfg_valid = 1'b0;
            cfg_if.cfg_data  = $urandom;
            cfg_if.cfg_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        cfg_if.cfg_last  = l;
        start            = st;
        w = 0;
        forever begin
            @(negedge clk);
            if (cfg_if.cfg_ready === 1'b1) break;
            w++;
            stalls++;
            if (w > 40) begin
                n_checks++;
                n_errors++;
                $display("FAIL ready_timeout: got 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
        start            = 1'b0;
    endtask

    task automatic run_stream(input int gaps, input int upto, input int start_at);
        int n;
        n = (upto < 0) ? stim_d.size() : upto;
        stalls = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < n; k++) send_word(stim_d[k], stim_l[k], gaps, (k == start_at));
    endtask

    task automatic finish_stream(input int gaps);
        int t;
        t = 0;
        while ((exp_shft.size() != 0 || exp_done.size() != 0) && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(exp_shft.size() + exp_done.size()), 64'(0));
        repeat (2) @(negedge clk);
        check("data_en_after", 64'(data_en_o), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
        if (gaps == 0) check("no_bubbles", 64'(stalls), 64'(0));
    endtask

    task automatic check_reset_vals();
        check("rst_prog_o", 64'(prog_o), 64'(0));
        check("rst_prog_shft", 64'(prog_shft), 64'(0));
        check("rst_cfg_ready", 64'(cfg_if.cfg_ready), 64'(0));
        check("rst_data_en", 64'(data_en_o), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
    endtask

    initial begin
        int nf;
        int gp;
        res              = 1'b1;
        start            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        cfg_if.cfg_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        res    = 1'b0;
        mon_en = 1;

        // Basic load, chain 2
        begin_stream();
        pay = '{32'hA, 32'hB, 32'hC};
        add_frame(2, 32'h0, 1);
        run_stream(0, -1, -1);
        finish_stream(0);

        // Same frame, checksum 0x0E instead of 0x0D
        begin_stream();
        pay = '{32'hA, 32'hB, 32'hC};
        add_frame(2, 32'h3, 1);
        run_stream(0, -1, -1);
        finish_stream(0);

        // Out-of-range chain, then a good frame
        begin_stream();
        pay = '{32'h1234_5678, 32'h9ABC_DEF0};
        add_frame(7, 32'h0, 0);
        pay = '{32'h0000_00F1, 32'h0000_00F2};
        add_frame(1, 32'h0, 1);
        run_stream(0, -1, -1);
        finish_stream(0);

        // Back-to-back frames with valid toggling
        begin_stream();
        pay = '{32'hCAFE_0001};
        add_frame(0, 32'h0, 0);
        pay.delete();
        add_frame(4, 32'h0, 1);
        run_stream(2, -1, -1);
        finish_stream(2);

        // Reset after 2 of 5 payload words
        begin_stream();
        pay = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        add_frame(1, 32'h0, 1);
        run_stream(0, 3, -1);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        exp_shft.delete();
        exp_done.delete();
        @(negedge clk);
        check_reset_vals();
        begin_stream();
        pay = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        add_frame(1, 32'h0, 1);
        run_stream(0, -1, -1);
        finish_stream(0);

        // start during LOAD must not restart the frame nor clear err
        begin_stream();
        pay = '{32'h5, 32'h6};
        add_frame(6, 32'h0, 0);
        pay = '{32'h100, 32'h200, 32'h300, 32'h400};
        add_frame(3, 32'h0, 1);
        run_stream(0, -1, 6);
        finish_stream(0);

        // Randomized streams
        for (int s = 0; s < 10; s++) begin
            begin_stream();
            nf = $urandom_range(1, 4);
            gp = $urandom_range(0, 1);
            for (int f = 0; f < nf; f++) begin
                pay.delete();
                for (int i = 0, n = $urandom_range(0, 5); i < n; i++) pay.push_back($urandom);
                add_frame($urandom_range(0, 7),
                          ($urandom_range(0, 3) == 0) ? (32'($urandom) | 32'h1) : 32'h0,
                          (f == nf - 1));
            end
            run_stream(gp, -1, -1);
            finish_stream(gp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
